div: RTL
========

# div

Multi-cycle 32-bit integer divider serving the execute stage for `div`/`divu`. EX launches a division with `start_i` and stalls the pipeline until `ready_o`. EX then writes the remainder to Hi and the quotient to Lo through its existing Hi/Lo write path. The divider is a radix-2 restoring design producing one quotient bit per cycle, with a dedicated divide-by-zero shortcut and an annul input for pipeline flushes.

## Interface
- none: no parameters; operand width is fixed at 32 bits (`RegBus`).

- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high (`RstEnable`)
- `signed_div_i`  in  1  1 = signed (`div`), 0 = unsigned (`divu`); sampled with `start_i`
- `opdata1_i`  in  32  dividend (rs); sampled with `start_i`
- `opdata2_i`  in  32  divisor (rt); sampled with `start_i`
- `start_i`  in  1  request; EX holds it high until it sees `ready_o`
- `annul_i`  in  1  cancel the in-flight or requested division (flush)
- `result_o`  out  64  {remainder[31:0], quotient[31:0]}; high half goes to Hi, low half to Lo
- `ready_o`  out  1  result valid

## Operation
- States:
  - FREE: idle.
  - BYZERO: divisor is zero.
  - ON: iterating.
  - END: result presented.
- Reset (`rst` = 1 at an edge):
  - state goes to FREE, cnt to 0, `ready_o` to 0, `result_o` to 0.
  - Reset has priority over every other input in every state, including mid-division.
- FREE:
  - `start_i` = 1 and `annul_i` = 0 with `opdata2_i` = 0 → BYZERO.
  - `start_i` = 1 and `annul_i` = 0 with `opdata2_i` ≠ 0 → ON.
    - Latch the magnitudes: if `signed_div_i` = 1 and the operand is negative, store its two's complement; otherwise store the raw value.
    - Latch sign1, sign2 and `signed_div_i`; set cnt to 0.
  - Otherwise stay in FREE; outputs are 0.
- BYZERO: next edge → END with `result_o` = 0 and `ready_o` = 1.
- ON:
  - If `annul_i` = 1 → FREE, `ready_o` = 0, `result_o` = 0; the partial result is discarded.
  - Else if cnt < 32, perform one restoring step:
    - shift the partial remainder left one bit, bringing in the next dividend bit, MSB first;
    - if the partial remainder ≥ divisor magnitude, subtract the divisor and shift in quotient bit 1; otherwise shift in 0;
    - increment cnt.
    - The partial remainder is 33 bits wide, so comparisons never overflow.
  - Else (cnt = 32) → END with `ready_o` = 1 and the sign-corrected result:
    - If signed and sign1 ≠ sign2, negate the quotient.
    - If signed and sign1 = 1, negate the remainder.
    - Unsigned results pass through uncorrected.
- END:
  - While `start_i` = 1, hold `ready_o` = 1 and `result_o` stable.
  - When `start_i` = 0 → FREE, `ready_o` = 0, `result_o` = 0.
  - `annul_i` is ignored in END.
- Arithmetic rules:
  - Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000 (wraps), remainder 0.
  - Remainder magnitude is always less than the divisor magnitude.
  - No exception is raised for any input; divide-by-zero yields 0.
- Operand changes on `opdata*_i` / `signed_div_i` after the launch edge have no effect.

## Timing
- Let E0 be the edge at which `start_i` is sampled in FREE.
- Normal division:
  - E0 enters ON.
  - Steps occur at E1–E32.
  - E33 enters END; `ready_o` is high from E33 onward.
- Divide-by-zero: E0 enters BYZERO; E1 enters END; `ready_o` is high from E1.
- Completion handshake:
  - EX drops `start_i` in the cycle after it sees `ready_o`.
  - The divider returns to FREE at the first edge with `start_i` = 0 in END.
  - A new division can launch at the following edge, so there is a 1-cycle minimum gap between results.
- Annul:
  - annul sampled in ON at edge Ek → FREE at Ek; no `ready_o` pulse.
  - `start_i` = 1 together with `annul_i` = 1 in FREE → no launch.
- All outputs are registered; no combinational path from input to output.

## Test plan
- Unsigned 100 / 7 (`signed_div_i` = 0) → at E33: `ready_o` = 1, `result_o` = {0x00000002, 0x0000000E}; `ready_o` = 0 at E32.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002) → {0xFFFFFFFF, 0xFFFFFFFD}. Signed 7 / −2 → {0x00000001, 0xFFFFFFFD}.
- Boundary operands:
  - signed 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000};
  - unsigned 0xFFFFFFFF / 0x00000001 → {0x00000000, 0xFFFFFFFF};
  - unsigned 3 / 5 → {0x00000003, 0x00000000}.
- Divide-by-zero: 1234 / 0 → `ready_o` = 1 at E1, `result_o` = 0. Hold `start_i` for 5 cycles → outputs stable. Drop `start_i` → next edge FREE, `ready_o` = 0.
- Annul at E10 in ON → FREE at E10, `ready_o` never asserts. An immediate relaunch of 100 / 7 completes correctly 33 edges later.
- `rst` = 1 at E15 mid-division → `ready_o` = 0, `result_o` = 0, FREE. Back-to-back divisions with a 1-cycle `start_i` gap both produce correct results.

Source files
------------

// File: rtl/div.sv
// div: radix-2 restoring 32-bit divider for div/divu, remainder in result_o[63:32], quotient in result_o[31:0]
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);
    typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;
    state_t state, state_n;
    logic [5:0]  cnt, cnt_n;
    logic [31:0] dvd, dvd_n, dsr, dsr_n, rem, rem_n;
    logic        neg_q, neg_q_n, neg_r, neg_r_n, ready_n;
    logic [63:0] result_n;
    logic [32:0] rem_sh;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FREE;
            cnt      <= '0;
            dvd      <= '0;
            dsr      <= '0;
            rem      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            ready_o  <= 1'b0;
            result_o <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            dvd      <= dvd_n;
            dsr      <= dsr_n;
            rem      <= rem_n;
            neg_q    <= neg_q_n;
            neg_r    <= neg_r_n;
            ready_o  <= ready_n;
            result_o <= result_n;
        end
    end
    // dvd shifts out dividend bits MSB first and shifts in quotient bits, ending as the quotient
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        dvd_n    = dvd;
        dsr_n    = dsr;
        rem_n    = rem;
        neg_q_n  = neg_q;
        neg_r_n  = neg_r;
        ready_n  = 1'b0;
        result_n = '0;
        rem_sh   = {rem, dvd[31]};
        case (state)
            S_FREE: begin
                if (start_i && !annul_i) begin
                    state_n = (opdata2_i == '0) ? S_BYZERO : S_ON;
                    dvd_n   = (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
                    dsr_n   = (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
                    rem_n   = '0;
                    cnt_n   = '0;
                    neg_q_n = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                    neg_r_n = signed_div_i && opdata1_i[31];
                end
            end
            S_BYZERO: begin
                state_n = S_END;
                ready_n = 1'b1;
            end
            S_ON: begin
                if (annul_i) begin
                    state_n = S_FREE;
                end else if (!cnt[5]) begin
                    rem_n = (rem_sh >= {1'b0, dsr}) ? rem_sh[31:0] - dsr : rem_sh[31:0];
                    dvd_n = {dvd[30:0], rem_sh >= {1'b0, dsr}};
                    cnt_n = cnt + 6'd1;
                end else begin
                    state_n  = S_END;
                    ready_n  = 1'b1;
                    result_n = {neg_r ? -rem : rem, neg_q ? -dvd : dvd};
                end
            end
            S_END: begin
                state_n  = start_i ? S_END : S_FREE;
                ready_n  = start_i;
                result_n = start_i ? result_o : '0;
            end
        endcase
    end
endmodule
